// File: rtl/axi_slv_mem_pkg.sv
// Shared types and AXI encodings for the memory-backed AXI4 slave responder.
package axi_slv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        WRESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_bus.sv
// Minimal AXI4 bus bundle carrying the channels the memory responder uses.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 1,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_valid, input w_ready,
        input b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, input ar_ready,
        input r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
    );

    modport Slave (
        input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, output aw_ready,
        input w_data, w_strb, w_last, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
    );

endinterface

// File: rtl/axi_slv_mem_addr_gen.sv
// Per-beat address decode and next-address generation shared by the read and write paths.
module axi_slv_mem_addr_gen
    import axi_slv_mem_pkg::*;
#(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          NumWords  = 256,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    localparam int unsigned         IdxWidth  = $clog2(NumWords)
) (
    input  logic [AddrWidth-1:0] addr,
    input  logic [2:0]           size,
    input  logic [1:0]           burst,
    output logic [AddrWidth-1:0] next_addr,
    output logic [IdxWidth-1:0]  word_idx,
    output logic                 out_of_range,
    output logic                 unsupported
);
    localparam int unsigned ByteOffW = $clog2(DataWidth / 8);
    localparam logic [63:0] MemBytes = 64'(NumWords) * 64'(DataWidth / 8);

    logic [AddrWidth-1:0] offset;

    // NOTE: every output is assigned on every pass through this block, so no latch can form.
    always_comb begin
        offset       = addr - BaseAddr;
        word_idx     = offset[ByteOffW +: IdxWidth];
        out_of_range = 64'(offset) >= MemBytes;
        // Only FIXED and INCR bursts at or below the bus width are served.
        unsupported  = (burst != BURST_FIXED && burst != BURST_INCR) || (size > 3'(ByteOffW));
        next_addr    = (burst == BURST_FIXED) ? addr : addr + (AddrWidth'(1) << size);
    end

endmodule

// File: rtl/axi_slv_mem_responder.sv
// AXI4 slave endpoint serving one burst at a time from an internal word-addressed memory.
module axi_slv_mem_responder
    import axi_slv_mem_pkg::*;
#(
    parameter int unsigned          IdWidth   = 1,
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          NumWords  = 256,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    AXI_BUS.Slave slv_port,
    output logic  busy_o
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned IdxWidth  = $clog2(NumWords);

    logic [DataWidth-1:0] mem [NumWords];

    state_e               state_q;
    logic                 rr_write_q;
    logic [IdWidth-1:0]   id_q;
    logic [AddrWidth-1:0] addr_q;
    logic [7:0]           len_q;
    logic [7:0]           beat_q;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic                 werr_q;
    logic                 r_valid_q;
    logic [DataWidth-1:0] r_data_q;
    logic [1:0]           r_resp_q;
    logic                 r_last_q;
    logic                 b_valid_q;
    logic [1:0]           b_resp_q;

    logic                 idle;
    logic                 both_valid;
    logic                 aw_hs, w_hs, ar_hs, r_hs, b_hs;
    logic [AddrWidth-1:0] ag_addr, ag_next;
    logic [2:0]           ag_size;
    logic [1:0]           ag_burst;
    logic [IdxWidth-1:0]  ag_idx;
    logic                 ag_oor, ag_unsup, beat_bad;
    logic                 werr_next;
    logic                 mem_we;

    assign idle       = (state_q == IDLE);
    assign both_valid = slv_port.ar_valid && slv_port.aw_valid;

    // When both address channels request at once, only the round-robin winner sees ready.
    assign slv_port.aw_ready = rst_ni && idle && !(both_valid && !rr_write_q);
    assign slv_port.ar_ready = rst_ni && idle && !(both_valid && rr_write_q);
    assign slv_port.w_ready  = rst_ni && (state_q == WR);

    assign aw_hs = slv_port.aw_valid && slv_port.aw_ready;
    assign ar_hs = slv_port.ar_valid && slv_port.ar_ready;
    assign w_hs  = slv_port.w_valid && slv_port.w_ready;
    assign r_hs  = r_valid_q && slv_port.r_ready;
    assign b_hs  = b_valid_q && slv_port.b_ready;

    // In IDLE the decoder looks at the incoming AR so the first beat loads on the accept edge;
    // afterwards it tracks addr_q, which is the next beat to load (read) or write (write).
    assign ag_addr  = idle ? slv_port.ar_addr  : addr_q;
    assign ag_size  = idle ? slv_port.ar_size  : size_q;
    assign ag_burst = idle ? slv_port.ar_burst : burst_q;

    axi_slv_mem_addr_gen #(
        .AddrWidth(AddrWidth),
        .DataWidth(DataWidth),
        .NumWords (NumWords),
        .BaseAddr (BaseAddr)
    ) u_addr_gen (
        .addr        (ag_addr),
        .size        (ag_size),
        .burst       (ag_burst),
        .next_addr   (ag_next),
        .word_idx    (ag_idx),
        .out_of_range(ag_oor),
        .unsupported (ag_unsup)
    );

    assign beat_bad  = ag_oor || ag_unsup;
    assign werr_next = werr_q || beat_bad || (slv_port.w_last != (beat_q == len_q));
    assign mem_we    = w_hs && !beat_bad;

    // NOTE: the memory array has no reset; its contents survive reset and are defined only by writes.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < StrbWidth; i++) begin
                if (slv_port.w_strb[i]) mem[ag_idx][i*8 +: 8] <= slv_port.w_data[i*8 +: 8];
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_write_q <= 1'b1;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            werr_q     <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            r_last_q   <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (both_valid) rr_write_q <= !rr_write_q;
                    if (aw_hs) begin
                        id_q    <= slv_port.aw_id;
                        addr_q  <= slv_port.aw_addr;
                        len_q   <= slv_port.aw_len;
                        size_q  <= slv_port.aw_size;
                        burst_q <= slv_port.aw_burst;
                        beat_q  <= '0;
                        werr_q  <= 1'b0;
                        state_q <= WR;
                    end else if (ar_hs) begin
                        id_q      <= slv_port.ar_id;
                        addr_q    <= ag_next;
                        len_q     <= slv_port.ar_len;
                        size_q    <= slv_port.ar_size;
                        burst_q   <= slv_port.ar_burst;
                        beat_q    <= '0;
                        r_valid_q <= 1'b1;
                        r_last_q  <= (slv_port.ar_len == 8'd0);
                        r_data_q  <= beat_bad ? '0 : mem[ag_idx];
                        r_resp_q  <= beat_bad ? RESP_SLVERR : RESP_OKAY;
                        state_q   <= RD;
                    end
                end
                RD: begin
                    if (r_hs) begin
                        if (r_last_q) begin
                            r_valid_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            beat_q   <= beat_q + 8'd1;
                            r_last_q <= (beat_q + 8'd1 == len_q);
                            addr_q   <= ag_next;
                            r_data_q <= beat_bad ? '0 : mem[ag_idx];
                            r_resp_q <= beat_bad ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                WR: begin
                    if (w_hs) begin
                        werr_q <= werr_next;
                        if (beat_q == len_q) begin
                            b_valid_q <= 1'b1;
                            b_resp_q  <= werr_next ? RESP_SLVERR : RESP_OKAY;
                            state_q   <= WRESP;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= ag_next;
                        end
                    end
                end
                WRESP: begin
                    if (b_hs) begin
                        b_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign slv_port.r_valid = r_valid_q;
    assign slv_port.r_data  = r_data_q;
    assign slv_port.r_resp  = r_resp_q;
    assign slv_port.r_last  = r_last_q;
    assign slv_port.r_id    = id_q;
    assign slv_port.r_user  = '0;
    assign slv_port.b_valid = b_valid_q;
    assign slv_port.b_resp  = b_resp_q;
    assign slv_port.b_id    = id_q;
    assign slv_port.b_user  = '0;

    assign busy_o = (state_q != IDLE);

endmodule

// File: doc/axi_slv_mem_responder.md
Name: axi_slv_mem_responder

Overview:
- AXI4 slave endpoint: the responder end of an `AXI_BUS` link.
- Terminates the `AXI_BUS.Slave` modport and serves reads and writes from an internal word-addressed register array.
- Used in the custom-instruction testbench as the target behind the flattened-master adapter, so the accelerator's AXI traffic hits a deterministic memory.
- One transaction in flight at a time; no reordering.

Parameters:
- IdWidth, 1, AXI ID width of `slv_port`.
- DataWidth, 32, AXI data width; power of two, ≥ 32.
- AddrWidth, 32, AXI address width.
- NumWords, 256, memory depth in DataWidth words; power of two.
- BaseAddr, 32'h0, byte address of word 0.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  synchronous active-low reset.
- `slv_port`  AXI_BUS.Slave  —  AXI4 slave interface (AW/W/B/AR/R).
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values:
  - all ready/valid outputs 0; `busy_o` 0; FSM in IDLE.
  - r_data, r_id, b_id, r_resp, b_resp are 0.
  - Memory contents are NOT reset; the bench preloads them via writes.
- FSM states: IDLE, RD, WR, WRESP.
  - IDLE: ar_ready and aw_ready are combinationally high.
  - AR handshake only → RD. AW handshake only → WR.
  - Both valid in the same cycle: accept only one, by a 1-bit round-robin flag. Reset value favours write; the flag toggles after each granted arbitration. Only the granted channel's ready is high that cycle.
- Captured on address accept: id, addr, len, size, burst.
- Beat counter: 8 bits, counts 0..len.
- Address decode:
  - word index = `(addr - BaseAddr) >> $clog2(DataWidth/8)`, truncated to `$clog2(NumWords)` bits.
  - out-of-range when `(addr - BaseAddr) >= NumWords*DataWidth/8` (unsigned).
- Address generation per beat:
  - FIXED: address unchanged.
  - INCR: `addr += 1 << size`, wrapping modulo 2^AddrWidth.
  - WRAP: unsupported; the whole burst responds SLVERR (2'b10), read data 0, writes dropped.
  - size > $clog2(DataWidth/8): same treatment as WRAP.
- RD state:
  - r_valid registered. The first beat is valid the cycle after the AR handshake (latency 1).
  - r_data, r_resp and r_last are held stable while r_valid && !r_ready.
  - Each r handshake advances the beat; the next beat is valid the following cycle, with no bubble required.
  - r_last=1 on beat len. After that handshake → IDLE.
  - r_resp: 2'b00 OKAY, or 2'b10 SLVERR per beat if that beat's address is out of range (data 0).
  - r_id = captured id.
- WR state:
  - w_ready high.
  - Each w handshake writes bytes where w_strb[i]=1 (in-range beats only).
  - After beat len is accepted → WRESP, regardless of w_last.
  - Any beat with w_last≠(beat==len) sets a sticky error bit.
- WRESP state:
  - b_valid high starting the cycle after the final W handshake.
  - b_resp = SLVERR if any beat was out of range, the burst was unsupported, or the w_last error bit is set; else OKAY.
  - b_id = captured id.
  - Hold until b_ready, then → IDLE.
- A W beat presented before its AW is not accepted (w_ready 0 outside WR).
- Reset asserted mid-burst: next edge returns to IDLE, deasserts all valids, and discards the in-flight transaction with no partial response. Memory writes already done are kept.
- All unused slave outputs are driven to 0: r_user, b_user.

Decomposition:
- Package `axi_slv_mem_pkg`:
  - state enum `state_e` {IDLE, RD, WR, WRESP}.
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - burst constants BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
- Sub-module `axi_slv_mem_addr_gen` (combinational):
  - inputs: addr, size, burst.
  - outputs: next_addr, word_idx, out_of_range, unsupported.
  - Shared by the RD and WR paths.

Test Plan:
- Single write then read:
  - Stimulus: AW addr 0x10, len 0, size 2, INCR, id 1; W data 0xDEADBEEF, strb 4'hF, last 1; then AR addr 0x10.
  - Required response: b_resp OKAY, b_id 1; r_data 0xDEADBEEF, r_last 1, first r_valid 1 cycle after AR handshake.
- INCR burst with r_ready stalls:
  - Stimulus: write 4 beats 0,1,2,3 at 0x20; read back len 3 with r_ready toggling 1,0,1,0.
  - Required response: beats in order; data and r_last held during stalls; r_last only on beat 3.
- Byte strobes:
  - Stimulus: write 0xFFFFFFFF to 0x40; then write 0x00000000 with strb 4'b0101.
  - Required response: readback 0xFF00FF00.
- Errors:
  - Stimulus: AR at BaseAddr+NumWords*4; then AW with WRAP burst, len 1.
  - Required response: read r_resp SLVERR with data 0; write b_resp SLVERR with memory unchanged.
  - Stimulus: a len-1 write with w_last on beat 0.
  - Required response: SLVERR.
- Arbitration and mid-burst reset:
  - Stimulus: AR and AW valid in the same cycle after reset.
  - Required response: write granted first; the next simultaneous pair grants read.
  - Stimulus: rst_ni low during beat 2 of a len-3 read.
  - Required response: r_valid 0 the next cycle, `busy_o` 0, new AR accepted immediately.
